// File: rtl/fpdiv_issue_queue.sv
// fpdiv_issue_queue: tagged request FIFO, single-outstanding issue FSM and
// registered response slot in front of fpdiv_scalar.
// Optional feature macro: FPDIV_ISSUE_BYPASS_EN (zero-cycle issue when idle and empty).
module fpdiv_issue_queue #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned TAG_W = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush_i,
    input  logic                     req_valid_i,
    output logic                     req_ready_o,
    input  logic [1:0]               req_fmt_i,
    input  logic [63:0]              req_opa_i,
    input  logic [63:0]              req_opb_i,
    input  logic [2:0]               req_rm_i,
    input  logic [TAG_W-1:0]         req_tag_i,
    output logic                     div_start_valid_o,
    input  logic                     div_start_ready_i,
    output logic                     div_flush_o,
    output logic [1:0]               div_fmt_o,
    output logic [63:0]              div_opa_o,
    output logic [63:0]              div_opb_o,
    output logic [2:0]               div_rm_o,
    input  logic                     div_finish_valid_i,
    output logic                     div_finish_ready_o,
    input  logic [63:0]              div_res_i,
    input  logic [4:0]               div_fflags_i,
    output logic                     rsp_valid_o,
    input  logic                     rsp_ready_i,
    output logic [63:0]              rsp_res_o,
    output logic [4:0]               rsp_fflags_o,
    output logic [TAG_W-1:0]         rsp_tag_o,
    output logic [$clog2(DEPTH):0]   occupancy_o
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = AW + 1;
    localparam int unsigned EW = 2 + 64 + 64 + 3 + TAG_W;

    typedef enum logic [1:0] {StIdle, StBusy, StResp} state_t;

    logic [EW-1:0]    r_mem [DEPTH];
    logic [PW-1:0]    r_wr_ptr;
    logic [PW-1:0]    r_rd_ptr;
    state_t           r_state;
    state_t           w_state_d;
    logic [TAG_W-1:0] r_tag;
    logic [63:0]      r_res;
    logic [4:0]       r_fflags;
    logic             r_div_flush;

    logic             w_empty;
    logic             w_full;
    logic             w_bypass;
    logic [EW-1:0]    w_issue;
    logic [TAG_W-1:0] w_issue_tag;
    logic             w_enq;
    logic             w_start;
    logic             w_pop;
    logic             w_finish;

    assign w_empty = (r_wr_ptr == r_rd_ptr);
    assign w_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);

`ifdef FPDIV_ISSUE_BYPASS_EN
    assign w_bypass = (r_state == StIdle) && w_empty;
`else
    assign w_bypass = 1'b0;
`endif

    // Issue fields come from the live request when bypassing, else the FIFO head
    assign w_issue = w_bypass ? {req_fmt_i, req_opa_i, req_opb_i, req_rm_i, req_tag_i}
                              : r_mem[r_rd_ptr[AW-1:0]];
    assign {div_fmt_o, div_opa_o, div_opb_o, div_rm_o, w_issue_tag} = w_issue;

    // Handshake and ready/valid decode; flush suppresses every handshake
    always_comb begin
        req_ready_o       = 1'b0;
        div_start_valid_o = 1'b0;
        if (w_bypass) begin
            req_ready_o       = div_start_ready_i && !flush_i;
            div_start_valid_o = req_valid_i && !flush_i;
        end else begin
            req_ready_o       = !w_full && !flush_i;
            div_start_valid_o = (r_state == StIdle) && !w_empty && !flush_i;
        end
    end

    assign w_enq              = req_valid_i && req_ready_o && !w_bypass;
    assign w_start            = div_start_valid_o && div_start_ready_i;
    assign w_pop              = w_start && !w_bypass;
    assign w_finish           = (r_state == StBusy) && div_finish_valid_i && !flush_i;
    assign div_finish_ready_o = (r_state == StBusy);
    assign rsp_valid_o        = (r_state == StResp);
    assign rsp_res_o          = r_res;
    assign rsp_fflags_o       = r_fflags;
    assign rsp_tag_o          = r_tag;
    assign div_flush_o        = r_div_flush;
    assign occupancy_o        = r_wr_ptr - r_rd_ptr;

    // FIFO pointers; flush empties the queue
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else if (flush_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_enq) r_wr_ptr <= r_wr_ptr + PW'(1);
            if (w_pop) r_rd_ptr <= r_rd_ptr + PW'(1);
        end
    end

    // FIFO storage, no reset needed: entries are only read when valid
    always_ff @(posedge clk) begin
        if (w_enq) begin
            r_mem[r_wr_ptr[AW-1:0]] <= {req_fmt_i, req_opa_i, req_opb_i, req_rm_i, req_tag_i};
        end
    end

    // Issue FSM next state: one request outstanding, response must drain first
    always_comb begin
        w_state_d = r_state;
        case (r_state)
            StIdle:  if (w_start) w_state_d = StBusy;
            StBusy:  if (div_finish_valid_i) w_state_d = StResp;
            StResp:  if (rsp_ready_i) w_state_d = StIdle;
            default: w_state_d = StIdle;
        endcase
        if (flush_i) w_state_d = StIdle;
    end

    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= StIdle;
        else     r_state <= w_state_d;
    end

    // In-flight tag, captured result and registered divider flush
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tag       <= '0;
            r_res       <= '0;
            r_fflags    <= '0;
            r_div_flush <= 1'b0;
        end else begin
            r_div_flush <= flush_i;
            if (w_start) r_tag <= w_issue_tag;
            if (w_finish) begin
                r_res    <= div_res_i;
                r_fflags <= div_fflags_i;
            end
        end
    end

endmodule

// File: tb/tb_fpdiv_issue_queue.sv
// Bench for fpdiv_issue_queue: plays the divider, keeps a queue-level model
// and checks every DUT output against it on each negative clock edge.
module tb_fpdiv_issue_queue;

    localparam int DEPTH = 4;
    localparam int TAG_W = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             flush_i;
    logic             req_valid_i;
    logic             req_ready_o;
    logic [1:0]       req_fmt_i;
    logic [63:0]      req_opa_i;
    logic [63:0]      req_opb_i;
    logic [2:0]       req_rm_i;
    logic [TAG_W-1:0] req_tag_i;
    logic             div_start_valid_o;
    logic             div_start_ready_i;
    logic             div_flush_o;
    logic [1:0]       div_fmt_o;
    logic [63:0]      div_opa_o;
    logic [63:0]      div_opb_o;
    logic [2:0]       div_rm_o;
    logic             div_finish_valid_i;
    logic             div_finish_ready_o;
    logic [63:0]      div_res_i;
    logic [4:0]       div_fflags_i;
    logic             rsp_valid_o;
    logic             rsp_ready_i;
    logic [63:0]      rsp_res_o;
    logic [4:0]       rsp_fflags_o;
    logic [TAG_W-1:0] rsp_tag_o;
    logic [2:0]       occupancy_o;

    always #5 clk = ~clk;

    fpdiv_issue_queue #(.DEPTH(DEPTH), .TAG_W(TAG_W)) u_dut (
        .clk                (clk),
        .rst                (rst),
        .flush_i            (flush_i),
        .req_valid_i        (req_valid_i),
        .req_ready_o        (req_ready_o),
        .req_fmt_i          (req_fmt_i),
        .req_opa_i          (req_opa_i),
        .req_opb_i          (req_opb_i),
        .req_rm_i           (req_rm_i),
        .req_tag_i          (req_tag_i),
        .div_start_valid_o  (div_start_valid_o),
        .div_start_ready_i  (div_start_ready_i),
        .div_flush_o        (div_flush_o),
        .div_fmt_o          (div_fmt_o),
        .div_opa_o          (div_opa_o),
        .div_opb_o          (div_opb_o),
        .div_rm_o           (div_rm_o),
        .div_finish_valid_i (div_finish_valid_i),
        .div_finish_ready_o (div_finish_ready_o),
        .div_res_i          (div_res_i),
        .div_fflags_i       (div_fflags_i),
        .rsp_valid_o        (rsp_valid_o),
        .rsp_ready_i        (rsp_ready_i),
        .rsp_res_o          (rsp_res_o),
        .rsp_fflags_o       (rsp_fflags_o),
        .rsp_tag_o          (rsp_tag_o),
        .occupancy_o        (occupancy_o)
    );

    typedef struct packed {
        logic [1:0]       fmt;
        logic [63:0]      a;
        logic [63:0]      b;
        logic [2:0]       rm;
        logic [TAG_W-1:0] tag;
    } req_t;

    // Model: queued requests, stage of the single outstanding op (0 none, 1 at divider, 2 held)
    req_t             mq[$];
    int               mstage;
    logic [TAG_W-1:0] mtag;
    logic [63:0]      mres;
    logic [4:0]       mfl;
    logic             mflush_q;

    // Divider emulation
    logic dv_busy;
    int   dv_cnt;
    req_t dv_req;
    int   lat;
    logic force_fin;
    logic stall;

    int               checks = 0;
    int               errors = 0;
    logic             last_acc;
    logic             last_rsp;
    logic [63:0]      cap_res;
    logic [4:0]       cap_fl;
    logic [TAG_W-1:0] cap_tag;
    int               rsp_seen;
    logic             rnd_mode;
    logic [TAG_W-1:0] exp_seq;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Divider result table: known quotients for the directed vectors, a scramble otherwise
    function automatic logic [68:0] golden(input req_t r);
        if (r.fmt == 2'd2 && r.a == 64'h3FF0000000000000 && r.b == 64'h4000000000000000)
            return {5'b00000, 64'h3FE0000000000000};
        if (r.fmt == 2'd0 && r.a == 64'h3C00 && r.b == 64'h0)
            return {5'b01000, 64'h0000000000007C00};
        if (r.fmt == 2'd1 && r.a == 64'h40400000 && r.b == 64'h3F800000)
            return {5'b00000, 64'h0000000040400000};
        return {r.a[4:0] ^ r.b[4:0], r.a ^ {r.b[31:0], r.b[63:32]}};
    endfunction

    // One clock: drive divider side, compare at negedge, advance the model
    task automatic tick();
        logic byp, e_rr, e_sv, shs, fhs, rhs, enq;
        req_t hd, cur;
        div_start_ready_i  = !dv_busy && !stall;
        div_finish_valid_i = (dv_busy && dv_cnt == 0) || force_fin;
        {div_fflags_i, div_res_i} = golden(dv_req);
        if (dv_busy && dv_cnt > 0) dv_cnt--;
        @(negedge clk);
        if (rst) begin
            mq.delete();
            mstage   = 0;
            mflush_q = 1'b0;
            dv_busy  = 1'b0;
        end
        cur = {req_fmt_i, req_opa_i, req_opb_i, req_rm_i, req_tag_i};
`ifdef FPDIV_ISSUE_BYPASS_EN
        byp = (mstage == 0) && (mq.size() == 0);
`else
        byp = 1'b0;
`endif
        e_rr = byp ? (div_start_ready_i && !flush_i) : (mq.size() < DEPTH && !flush_i);
        e_sv = byp ? (req_valid_i && !flush_i) : (mstage == 0 && mq.size() > 0 && !flush_i);
        hd   = byp ? cur : ((mq.size() > 0) ? mq[0] : '0);
        chk("req_ready", req_ready_o, e_rr);
        chk("start_valid", div_start_valid_o, e_sv);
        chk("finish_ready", div_finish_ready_o, mstage == 1);
        chk("rsp_valid", rsp_valid_o, mstage == 2);
        chk("occupancy", occupancy_o, mq.size());
        chk("div_flush", div_flush_o, mflush_q);
        if (e_sv) begin
            chk("div_fmt", div_fmt_o, hd.fmt);
            chk("div_opa", div_opa_o, hd.a);
            chk("div_opb", div_opb_o, hd.b);
            chk("div_rm", div_rm_o, hd.rm);
        end
        if (mstage == 2) begin
            chk("rsp_res", rsp_res_o, mres);
            chk("rsp_fflags", rsp_fflags_o, mfl);
            chk("rsp_tag", rsp_tag_o, mtag);
        end
        last_acc = req_valid_i && e_rr && !rst;
        last_rsp = 1'b0;
        if (!rst) begin
            if (flush_i) begin
                mq.delete();
                mstage  = 0;
                dv_busy = 1'b0;
            end else begin
                shs = e_sv && div_start_ready_i;
                fhs = (mstage == 1) && div_finish_valid_i;
                rhs = (mstage == 2) && rsp_ready_i;
                enq = req_valid_i && e_rr && !byp;
                if (rhs) begin
                    last_rsp = 1'b1;
                    cap_res  = rsp_res_o;
                    cap_fl   = rsp_fflags_o;
                    cap_tag  = rsp_tag_o;
                    rsp_seen++;
                    if (rnd_mode) begin
                        chk("tag_order", rsp_tag_o, exp_seq);
                        exp_seq++;
                    end
                    mstage = 0;
                end
                if (fhs) begin
                    mres    = div_res_i;
                    mfl     = div_fflags_i;
                    mstage  = 2;
                    dv_busy = 1'b0;
                end
                if (shs) begin
                    if (byp) dv_req = cur;
                    else     dv_req = mq.pop_front();
                    mtag    = dv_req.tag;
                    mstage  = 1;
                    dv_busy = 1'b1;
                    dv_cnt  = lat;
                end
                if (enq) mq.push_back(cur);
            end
            mflush_q = flush_i;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input logic [1:0] f, input logic [63:0] a, input logic [63:0] b,
                           input logic [2:0] rm, input logic [TAG_W-1:0] t);
        req_valid_i = 1'b1;
        req_fmt_i   = f;
        req_opa_i   = a;
        req_opb_i   = b;
        req_rm_i    = rm;
        req_tag_i   = t;
    endtask

    task automatic send(input logic [1:0] f, input logic [63:0] a, input logic [63:0] b,
                        input logic [2:0] rm, input logic [TAG_W-1:0] t);
        int n = 0;
        set_req(f, a, b, rm, t);
        do begin
            tick();
            n++;
        end while (!last_acc && n < 50);
        chk("send_accept", last_acc, 1);
        req_valid_i = 1'b0;
    endtask

    task automatic wait_rsp();
        int n = 0;
        rsp_ready_i = 1'b1;
        do begin
            tick();
            n++;
        end while (!last_rsp && n < 100);
        chk("rsp_arrived", last_rsp, 1);
    endtask

    initial begin
        int acc;
        int cnt;
        int issued;
        int base;
        int cyc;
        logic [TAG_W-1:0] nt;

        rst = 1'b1; flush_i = 1'b0; req_valid_i = 1'b0; req_fmt_i = '0; req_opa_i = '0;
        req_opb_i = '0; req_rm_i = '0; req_tag_i = '0; rsp_ready_i = 1'b0;
        div_start_ready_i = 1'b0; div_finish_valid_i = 1'b0; div_res_i = '0; div_fflags_i = '0;
        mstage = 0; mtag = '0; mres = '0; mfl = '0; mflush_q = 1'b0;
        dv_busy = 1'b0; dv_cnt = 0; dv_req = '0; lat = 2; force_fin = 1'b0; stall = 1'b0;
        last_acc = 1'b0; last_rsp = 1'b0; cap_res = '0; cap_fl = '0; cap_tag = '0;
        rsp_seen = 0; rnd_mode = 1'b0; exp_seq = '0;
        @(posedge clk);
        #1;

        // Reset values
        tick();
        chk("reset_req_ready", req_ready_o, 1);
        chk("reset_occ", occupancy_o, 0);
        chk("reset_rsp_res", rsp_res_o, 0);
        chk("reset_rsp_valid", rsp_valid_o, 0);
        rst = 1'b0;
        tick();

        // FP64 1.0 / 2.0
`ifdef FPDIV_ISSUE_BYPASS_EN
        set_req(2'd2, 64'h3FF0000000000000, 64'h4000000000000000, 3'd0, 4'd5);
        #1;
        chk("bypass_same_cycle", div_start_valid_o, 1);
`endif
        send(2'd2, 64'h3FF0000000000000, 64'h4000000000000000, 3'd0, 4'd5);
        wait_rsp();
        chk("t1_res", cap_res, 64'h3FE0000000000000);
        chk("t1_fflags", cap_fl, 0);
        chk("t1_tag", cap_tag, 5);

        // FP16 divide by zero, then FP32 3.0 / 1.0
        send(2'd0, 64'h3C00, 64'h0, 3'd0, 4'd2);
        wait_rsp();
        chk("t2_res", cap_res, 64'h0000000000007C00);
        chk("t2_fflags", cap_fl, 5'b01000);
        chk("t2_tag", cap_tag, 2);
        send(2'd1, 64'h40400000, 64'h3F800000, 3'd1, 4'd3);
        wait_rsp();
        chk("t2b_res", cap_res, 64'h0000000040400000);
        chk("t2b_fflags", cap_fl, 0);

        // Back-pressure: six back-to-back requests with the response held
        lat = 0;
        rsp_ready_i = 1'b0;
        acc = 0;
        for (int i = 0; i < 6; i++) begin
            set_req(2'd1, 64'(i) + 64'h100, 64'h3F800000, 3'(i % 5), 4'(i));
            tick();
            if (last_acc) acc++;
        end
        req_valid_i = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        chk("full_accepted", acc, 5);
        chk("full_req_ready", req_ready_o, 0);
        chk("full_occ", occupancy_o, 4);
        for (int i = 0; i < 5; i++) begin
            wait_rsp();
            chk("full_tag_order", cap_tag, i);
        end

        // Flush while busy with three queued
        lat = 20;
        rsp_ready_i = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            set_req(2'd2, 64'(i), 64'h4000000000000000, 3'd0, 4'(i));
            tick();
        end
        req_valid_i = 1'b0;
        tick();
        chk("pre_flush_occ", occupancy_o, 3);
        chk("pre_flush_busy", div_finish_ready_o, 1);
        flush_i = 1'b1;
        tick();
        flush_i = 1'b0;
        chk("flush_pulse", div_flush_o, 1);
        chk("flush_occ", occupancy_o, 0);
        cnt = 0;
        for (int i = 0; i < 25; i++) begin
            tick();
            if (rsp_valid_o) cnt++;
        end
        chk("flush_no_rsp", cnt, 0);
        chk("flush_pulse_end", div_flush_o, 0);
        lat = 2;
        send(2'd1, 64'h40400000, 64'h3F800000, 3'd0, 4'd9);
        wait_rsp();
        chk("post_flush_tag", cap_tag, 9);
        chk("post_flush_res", cap_res, 64'h0000000040400000);

        // Reset while a response is held; stray finish_valid while idle must be ignored
        rsp_ready_i = 1'b0;
        lat = 1;
        send(2'd0, 64'h3C00, 64'h0, 3'd0, 4'd6);
        for (int i = 0; i < 6; i++) tick();
        chk("held_rsp_valid", rsp_valid_o, 1);
        rst = 1'b1;
        tick();
        chk("rst_rsp_valid", rsp_valid_o, 0);
        chk("rst_rsp_res", rsp_res_o, 0);
        chk("rst_occ", occupancy_o, 0);
        chk("rst_req_ready", req_ready_o, 1);
        rst = 1'b0;
        rsp_ready_i = 1'b1;
        force_fin = 1'b1;
        cnt = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (rsp_valid_o) cnt++;
        end
        force_fin = 1'b0;
        chk("rst_no_stale_rsp", cnt, 0);

        // Randomised handshake timing, tags must return in order
        rnd_mode = 1'b1;
        exp_seq = '0;
        nt = '0;
        issued = 0;
        base = rsp_seen;
        cyc = 0;
        while ((rsp_seen - base) < 300 && cyc < 20000) begin
            if (!req_valid_i && issued < 300 && $urandom_range(0, 3) == 0) begin
                set_req(2'($urandom_range(0, 2)), {$urandom, $urandom}, {$urandom, $urandom},
                        3'($urandom_range(0, 4)), nt);
            end
            rsp_ready_i = ($urandom_range(0, 1) == 1);
            stall       = ($urandom_range(0, 3) == 0);
            lat         = $urandom_range(0, 7);
            tick();
            if (last_acc) begin
                req_valid_i = 1'b0;
                nt++;
                issued++;
            end
            cyc++;
        end
        rnd_mode = 1'b0;
        stall = 1'b0;
        chk("rnd_completed", rsp_seen - base, 300);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
